// File: rtl/seg_pipe_adder.sv
// Segmented, pipelined adder/subtractor: one SEG-bit segment per stage, then a result register.
// Optional build macro SEG_PIPE_ADDER_SAT_EN clamps sum to the signed limit on overflow.
module seg_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;

    // Handshake: a beat moves in on in_valid & in_ready and out on out_valid & out_ready.
    // The whole pipe, bubbles included, advances only when the result slot is empty or drained.
    logic advance;

    logic [WIDTH-1:0] beff;
    logic             c0;

    // Stage inputs (muxed from the previous rank) and combinational segment results
    logic [WIDTH-1:0] sin_a [STAGES];
    logic [WIDTH-1:0] sin_b [STAGES];
    logic [WIDTH-1:0] sin_s [STAGES];
    logic             sin_c [STAGES];
    logic             sin_v [STAGES];
    logic [SEG:0]     seg_res [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];

    // Per-stage registers: skewed operands, partial sum, carry, valid
    logic [WIDTH-1:0] op_a [STAGES];
    logic [WIDTH-1:0] op_b [STAGES];
    logic [WIDTH-1:0] ps   [STAGES];
    logic             cy   [STAGES];
    logic             vld  [STAGES];

    logic [WIDTH-1:0] fin_sum;
    logic             fin_cout;
    logic             fin_ovf;
    logic             msb_a;
    logic             msb_b;

    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_ovf;
    logic             res_v;

    assign advance   = !res_v || out_ready;
    assign in_ready  = advance;
    assign out_valid = res_v;
    assign sum       = res_sum;
    assign cout      = res_cout;
    assign ovf       = res_ovf;

    always_comb begin
        beff     = sub ? ~b : b;
        c0       = sub | cin;
        sin_a[0] = a;
        sin_b[0] = beff;
        sin_s[0] = '0;
        sin_c[0] = c0;
        sin_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            sin_a[k] = op_a[k-1];
            sin_b[k] = op_b[k-1];
            sin_s[k] = ps[k-1];
            sin_c[k] = cy[k-1];
            sin_v[k] = vld[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            seg_res[k] = {1'b0, sin_a[k][k*SEG +: SEG]}
                       + {1'b0, sin_b[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, sin_c[k]};
            nxt_s[k] = sin_s[k];
            nxt_s[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
        end
    end

    // Carry into the MSB is recovered as a ^ beff ^ sum at that bit.
    always_comb begin
        msb_a    = op_a[STAGES-1][WIDTH-1];
        msb_b    = op_b[STAGES-1][WIDTH-1];
        fin_cout = cy[STAGES-1];
        fin_ovf  = (msb_a ^ msb_b ^ ps[STAGES-1][WIDTH-1]) ^ fin_cout;
        fin_sum  = ps[STAGES-1];
`ifdef SEG_PIPE_ADDER_SAT_EN
        if (fin_ovf) begin
            fin_sum = msb_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                op_a[k] <= '0;
                op_b[k] <= '0;
                ps[k]   <= '0;
                cy[k]   <= 1'b0;
                vld[k]  <= 1'b0;
            end
            res_v    <= 1'b0;
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_ovf  <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                op_a[k] <= sin_a[k];
                op_b[k] <= sin_b[k];
                ps[k]   <= nxt_s[k];
                cy[k]   <= seg_res[k][SEG];
                vld[k]  <= sin_v[k];
            end
            res_v <= vld[STAGES-1];
            if (vld[STAGES-1]) begin
                res_sum  <= fin_sum;
                res_cout <= fin_cout;
                res_ovf  <= fin_ovf;
            end
        end
    end

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed-vector bench for seg_pipe_adder (WIDTH=16, SEG=4): table vectors, stream, reset abort.
module tb_seg_pipe_adder;
    localparam int W   = 16;
    localparam int S   = 4;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    seg_pipe_adder #(.WIDTH(W), .SEG(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vt [11];
    int n_vec = 0;
    int n_err = 0;
    logic [W+1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [W-1:0] be;
        logic         c;
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         ov;
        be   = msub ? ~mb : mb;
        c    = msub ? 1'b1 : mcin;
        full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, c};
        s    = full[W-1:0];
        ov   = (ma[W-1] == be[W-1]) && (s[W-1] != ma[W-1]);
`ifdef SEG_PIPE_ADDER_SAT_EN
        if (ov) s = ma[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return {s, full[W], ov};
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int cnt;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check($sformatf("%s latency", tag), cnt - 1, LAT);
        check($sformatf("%s sum", tag), sum, v.sum);
        check($sformatf("%s cout", tag), cout, v.cout);
        check($sformatf("%s ovf", tag), ovf, v.ovf);
    endtask

    initial begin
        logic [W-1:0] na, nb;
        logic         ncin, nsub;
        logic [W+1:0] e;
        int sent, got, cyc, seen;
        vec_t pr;

        //            a        b        cin   sub   sum      cout  ovf
        vt[0]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
`ifdef SEG_PIPE_ADDER_SAT_EN
        vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vt[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
        vt[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1};
        vt[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
`else
        vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
`endif
        vt[2]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vt[4]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[6]  = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[7]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
        vt[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[9]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        // Reset, then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle out_valid", out_valid, 1'b0);
            check("idle sum", sum, 16'h0000);
            check("idle in_ready", in_ready, 1'b1);
        end
        check("idle cout", cout, 1'b0);
        check("idle ovf", ovf, 1'b0);

        for (int i = 0; i < 11; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Back-to-back stream with random backpressure
        sent = 0; got = 0; cyc = 0;
        na = W'($urandom); nb = W'($urandom);
        ncin = 1'($urandom_range(0, 1)); nsub = 1'($urandom_range(0, 1));
        while (got < 20 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (sent < 20) begin
                in_valid = 1'b1; a = na; b = nb; cin = ncin; sub = nsub;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("stream in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream unexpected beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream result", {sum, cout, ovf}, e);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                sent++;
                na = W'($urandom); nb = W'($urandom);
                ncin = 1'($urandom_range(0, 1)); nsub = 1'($urandom_range(0, 1));
            end
        end
        check("stream beats out", got, 20);
        check("stream leftovers", exp_q.size(), 0);

        // Reset while three beats are in flight
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            a = 16'h1111 * W'(i + 1); b = 16'h0101; cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort in_ready", in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("abort no output", seen, 0);
        pr = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        run_vec(pr, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_pipe_adder.md
Name: seg_pipe_adder

Overview:
- Parametrised, pipelined signed/unsigned adder-subtractor. Successor to the single-bit half adder cell.
- The WIDTH-bit operation is split into SEG-bit segments. Each pipeline stage resolves one segment and registers the carry into the next stage.
- Used as the wide final-sum and accumulate adder behind the Booth partial-product array. Valid/ready streaming interface with backpressure.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage. Range 1 to WIDTH.
- STAGES, WIDTH/SEG, derived value, not overridable. Pipeline depth, equal to the latency.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in; ignored when sub=1
- sub  in  1  0: a+b+cin; 1: a-b, computed as a+~b+1
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; in subtract mode 1 means no borrow
- ovf  out  1  signed overflow flag

Behaviour:
- Reset, synchronous, rst=1 at a clock edge: clears every stage valid bit, stored carry, operand skew register and result register.
  - After reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
  - Reset mid-operation discards all in-flight beats; nothing partial is ever emitted.
- Advance rule: advance = !out_valid | out_ready; in_ready = advance, combinational.
  - When advance=0, every stage register holds, including bubbles.
  - A beat transfers in when in_valid & in_ready; a beat transfers out when out_valid & out_ready.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES, provided no stalls occur.
  - Throughput is 1 beat per cycle.
  - Bubbles propagate as valid=0 stages. Order is strictly preserved.
- Operand conditioning at stage 0:
  - beff = sub ? ~b : b
  - c0 = sub ? 1 : cin
- Stage k (0..STAGES-1):
  - Adds segment k of a and beff plus the carry registered by stage k-1 (stage 0 uses c0).
  - Registers the SEG-bit partial sum and the segment carry-out.
- Skew/deskew:
  - Operand segments above k are delayed k cycles so they reach stage k together with their carry.
  - Lower result segments are delayed so all WIDTH bits of sum leave in the same cycle.
- cout: carry out of the top segment.
- ovf: carry into the MSB XOR carry out of the MSB, computed on the effective operands (a, beff, c0). Valid in both modes.
- SEG=WIDTH case: single stage, latency 1, same handshake.
- Wrap-around is modulo 2^WIDTH. sum is never widened.
- Simultaneous out and in transfer in one cycle is legal and loses no beat.

Optional Feature:
- Macro: SEG_PIPE_ADDER_SAT_EN.
- Defined: when ovf=1, sum is replaced with the signed limit in the same output cycle.
  - 0111..1 if the effective operand MSBs are both 0.
  - 1000..0 if both are 1.
  - cout and ovf are reported unchanged.
- Undefined: sum is the plain wrapped result and no saturation logic is built.

Test Plan:
All cases use WIDTH=16, SEG=4, so latency is 4.
- Reset then idle -> out_valid=0, sum=0x0000, in_ready=1, held for 10 cycles.
- a=0x1234, b=0x4321, cin=1, sub=0 -> 4 cycles later: sum=0x5556, cout=0, ovf=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0.
  - With SEG_PIPE_ADDER_SAT_EN: sum=0x7FFF, ovf=1.
- a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1; saturated build gives 0x8000.
- Stream 20 random back-to-back beats, out_ready toggling pseudo-randomly -> all 20 results match a reference model, in order, with no drops or duplicates.
  - in_ready=0 exactly in cycles where out_valid=1 and out_ready=0.
- Stream 3 beats, assert rst on the edge where the second beat is in stage 2 -> no output appears. The next post-reset beat 0xFFFF+0x0001 gives sum=0x0000, cout=1.
